duck_round_ctrl: RTL
====================

Name: duck_round_ctrl

Overview:
Game-sequencing controller for the Duck Hunt design, in the 65 MHz pixel-clock domain beside the VGA draw chain.
- Consumes the per-frame tick, mouse shot pulses and hit-detection results.
- Schedules duck spawns, flight timeouts, hit/escape animations, round progression and game over.
- Drives the duck sprite mover, the score/HUD overlay and the speed configuration of the duck path generator.

Parameters:
SHOTS_PER_DUCK, 3, shots granted per duck
DUCKS_PER_ROUND, 10, ducks launched per round
PASS_HITS, 6, hits needed in a round to advance
FLY_FRAMES, 300, frames a duck flies before escaping
ANIM_FRAMES, 60, frames spent in HIT (fall) or ESCAPE animation
HIT_POINTS, 500, score added per hit
SCORE_W, 16, score width; saturating
MAX_ROUND, 15, last round; round counter saturates here

Ports:
clk  in  1  pixel clock (65 MHz)
rst  in  1  synchronous active-high reset
frame_tick  in  1  one-cycle pulse per frame (vsync start)
start  in  1  one-cycle pulse: start/restart game
shot  in  1  one-cycle pulse: mouse left click
hit  in  1  hit-detection result; valid only in the same cycle as shot
state  out  3  current FSM state (shared enum)
duck_active  out  1  duck sprite drawn and moving
duck_spawn  out  1  one-cycle pulse: mover loads new start position
duck_fall  out  1  high in HIT state
duck_escape  out  1  high in ESCAPE state
shots_left  out  2  remaining shots for current duck
duck_idx  out  4  duck number within round, 0..DUCKS_PER_ROUND-1
ducks_hit  out  4  hits in current round
round  out  4  current round, 1..MAX_ROUND; also the speed level
score  out  SCORE_W  accumulated score
game_over  out  1  high in GAME_OVER state

Behaviour:
- Reset
  - state=IDLE; all counters 0; round=1; all outputs low.
  - rst mid-game wins over every other input and returns to IDLE in one cycle.
- Registered outputs: every output reflects the state/counters of the current cycle; no combinational path from inputs to outputs.
- IDLE: start -> SPAWN with score=0, round=1, duck_idx=0, ducks_hit=0.
- SPAWN (1 cycle)
  - duck_spawn=1, shots_left=SHOTS_PER_DUCK, frame timer=FLY_FRAMES-1.
  - Always -> FLYING.
- FLYING
  - duck_active=1.
  - On shot with shots_left>0: shots_left decrements.
  - If hit is also high: score += HIT_POINTS (saturate at 2^SCORE_W-1), ducks_hit++, timer=ANIM_FRAMES-1 -> HIT.
  - A shot with shots_left==0 is ignored.
  - A miss that brings shots_left to 0 -> ESCAPE (timer=ANIM_FRAMES-1).
  - On frame_tick the timer decrements; frame_tick with timer==0 -> ESCAPE.
  - Shot+hit in the same cycle as expiry: hit wins.
  - hit without shot is ignored.
- HIT / ESCAPE
  - duck_active=0; duck_fall or duck_escape held high; shots ignored.
  - The timer decrements on frame_tick; at 0 with frame_tick -> NEXT.
- NEXT (1 cycle)
  - If duck_idx==DUCKS_PER_ROUND-1 -> ROUND_END.
  - Otherwise duck_idx++ -> SPAWN.
- ROUND_END (1 cycle)
  - If ducks_hit>=PASS_HITS: round++ (saturates at MAX_ROUND), duck_idx=0, ducks_hit=0 -> SPAWN.
  - Otherwise -> GAME_OVER.
- GAME_OVER
  - game_over=1; score, round and ducks_hit are held for the HUD.
  - start -> same initialisation as IDLE+start.
- start in any state other than IDLE/GAME_OVER is ignored.
- Latency: shot to score/shots_left update, 1 cycle. Timer expiry to state change, 1 cycle after the frame_tick edge.

Decomposition:
- Shared package (duck_hunt_pkg):
  - state enum: IDLE, SPAWN, FLYING, HIT, ESCAPE, NEXT, ROUND_END, GAME_OVER (3-bit).
  - Default constants for shots, ducks/round, frame counts, points.
- One natural sub-module: frame_timer.
  - Loadable down-counter advanced by frame_tick.
  - Outputs a done flag at zero.
  - Reused for both flight and animation timing.

Test Plan:
1. Reset then start -> duck_spawn pulses 1 cycle later, then FLYING with shots_left=3, round=1, score=0.
2. In FLYING, shot+hit on the same cycle -> score=500, ducks_hit=1, state=HIT; after 60 frame_ticks, NEXT then SPAWN with duck_idx=1.
3. Three shots with hit=0 -> shots_left 3->2->1->0, ESCAPE entered the cycle after the third shot; a fourth shot is ignored.
4. No shots for 300 frame_ticks -> ESCAPE on the 300th tick. Separately, shot+hit coinciding with that tick -> HIT, score +500.
5. Full round with 6 hits and 4 escapes -> ROUND_END then SPAWN with round=2, ducks_hit=0. Full round with 5 hits -> GAME_OVER, game_over=1, score=2500 held; start restarts with score=0.
6. Assert rst mid-FLYING with score=1500 -> next cycle state=IDLE, score=0, all outputs low.

Source files
------------

// File: rtl/duck_hunt_pkg.sv
// Shared types and default constants for the Duck Hunt game sequencer.
package duck_hunt_pkg;

   // Game sequencing states, visible on the state output of duck_round_ctrl.
   typedef enum logic [2:0] {
      StIdle      = 3'd0,
      StSpawn     = 3'd1,
      StFlying    = 3'd2,
      StHit       = 3'd3,
      StEscape    = 3'd4,
      StNext      = 3'd5,
      StRoundEnd  = 3'd6,
      StGameOver  = 3'd7
   } duck_state_e;

   localparam int unsigned DEF_SHOTS_PER_DUCK  = 3;
   localparam int unsigned DEF_DUCKS_PER_ROUND = 10;
   localparam int unsigned DEF_PASS_HITS       = 6;
   localparam int unsigned DEF_FLY_FRAMES      = 300;
   localparam int unsigned DEF_ANIM_FRAMES     = 60;
   localparam int unsigned DEF_HIT_POINTS      = 500;
   localparam int unsigned DEF_SCORE_W         = 16;
   localparam int unsigned DEF_MAX_ROUND       = 15;

   // Larger of two values; used to size the shared frame timer.
   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/frame_timer.sv
// Loadable down-counter advanced by the per-frame tick; flags done at zero.
module frame_timer #(
   parameter int unsigned WIDTH = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             tick,
   output logic             done
);

   logic [WIDTH-1:0] count_q;

   // Load wins over tick; the counter parks at zero rather than wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (tick && (count_q != '0)) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign done = (count_q == '0);

endmodule

// File: rtl/duck_round_ctrl.sv
// Duck Hunt game sequencer: spawns ducks, tracks shots, hits, rounds and score.
module duck_round_ctrl
   import duck_hunt_pkg::*;
#(
   parameter int unsigned SHOTS_PER_DUCK  = DEF_SHOTS_PER_DUCK,
   parameter int unsigned DUCKS_PER_ROUND = DEF_DUCKS_PER_ROUND,
   parameter int unsigned PASS_HITS       = DEF_PASS_HITS,
   parameter int unsigned FLY_FRAMES      = DEF_FLY_FRAMES,
   parameter int unsigned ANIM_FRAMES     = DEF_ANIM_FRAMES,
   parameter int unsigned HIT_POINTS      = DEF_HIT_POINTS,
   parameter int unsigned SCORE_W         = DEF_SCORE_W,
   parameter int unsigned MAX_ROUND       = DEF_MAX_ROUND
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_tick,
   input  logic               start,
   input  logic               shot,
   input  logic               hit,
   output logic [2:0]         state,
   output logic               duck_active,
   output logic               duck_spawn,
   output logic               duck_fall,
   output logic               duck_escape,
   output logic [1:0]         shots_left,
   output logic [3:0]         duck_idx,
   output logic [3:0]         ducks_hit,
   output logic [3:0]         round,
   output logic [SCORE_W-1:0] score,
   output logic               game_over
);

   localparam int unsigned TIMER_W     = $clog2(max_u(max_u(FLY_FRAMES, ANIM_FRAMES), 2));
   localparam int unsigned SCORE_SUM_W = SCORE_W + 1;

   localparam logic [TIMER_W-1:0] FLY_LOAD   = TIMER_W'(FLY_FRAMES - 1);
   localparam logic [TIMER_W-1:0] ANIM_LOAD  = TIMER_W'(ANIM_FRAMES - 1);
   localparam logic [1:0]         SHOTS_INIT = 2'(SHOTS_PER_DUCK);
   localparam logic [3:0]         LAST_IDX   = 4'(DUCKS_PER_ROUND - 1);
   localparam logic [3:0]         PASS_V     = 4'(PASS_HITS);
   localparam logic [3:0]         MAX_RND_V  = 4'(MAX_ROUND);

   duck_state_e        state_q, state_d;
   logic [1:0]         shots_q, shots_d;
   logic [3:0]         idx_q, idx_d;
   logic [3:0]         hits_q, hits_d;
   logic [3:0]         round_q, round_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic               active_q, spawn_q, fall_q, escape_q, over_q;

   logic               tmr_load;
   logic [TIMER_W-1:0] tmr_val;
   logic               tmr_tick;
   logic               tmr_done;
   logic               expire;
   logic               shot_ok;
   logic               launch;
   logic [SCORE_SUM_W-1:0] score_sum;
   logic [SCORE_W-1:0]     score_sat;

   frame_timer #(
      .WIDTH (TIMER_W)
   ) u_frame_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .tick     (tmr_tick),
      .done     (tmr_done)
   );

   // Timer only runs while a duck is in flight or animating.
   assign tmr_tick  = frame_tick && (state_q inside {StFlying, StHit, StEscape});
   assign expire    = frame_tick && tmr_done;
   assign shot_ok   = shot && (shots_q != 2'd0);
   assign score_sum = {1'b0, score_q} + SCORE_SUM_W'(HIT_POINTS);
   assign score_sat = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

   // Next-state and counter updates; launch collects every path into SPAWN.
   always_comb begin
      state_d  = state_q;
      shots_d  = shots_q;
      idx_d    = idx_q;
      hits_d   = hits_q;
      round_d  = round_q;
      score_d  = score_q;
      tmr_load = 1'b0;
      tmr_val  = FLY_LOAD;
      launch   = 1'b0;

      unique case (state_q)
         StIdle, StGameOver: begin
            if (start) begin
               score_d = '0;
               round_d = 4'd1;
               idx_d   = 4'd0;
               hits_d  = 4'd0;
               launch  = 1'b1;
            end
         end
         StSpawn: begin
            state_d = StFlying;
         end
         StFlying: begin
            if (shot_ok) begin
               shots_d = shots_q - 2'd1;
            end
            // A hit beats both the last miss and a coincident timeout.
            if (shot_ok && hit) begin
               score_d  = score_sat;
               hits_d   = hits_q + 4'd1;
               tmr_load = 1'b1;
               tmr_val  = ANIM_LOAD;
               state_d  = StHit;
            end else if ((shot_ok && (shots_q == 2'd1)) || expire) begin
               tmr_load = 1'b1;
               tmr_val  = ANIM_LOAD;
               state_d  = StEscape;
            end
         end
         StHit, StEscape: begin
            if (expire) begin
               state_d = StNext;
            end
         end
         StNext: begin
            if (idx_q == LAST_IDX) begin
               state_d = StRoundEnd;
            end else begin
               idx_d  = idx_q + 4'd1;
               launch = 1'b1;
            end
         end
         StRoundEnd: begin
            if (hits_q >= PASS_V) begin
               round_d = (round_q >= MAX_RND_V) ? MAX_RND_V : round_q + 4'd1;
               idx_d   = 4'd0;
               hits_d  = 4'd0;
               launch  = 1'b1;
            end else begin
               state_d = StGameOver;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (launch) begin
         state_d  = StSpawn;
         shots_d  = SHOTS_INIT;
         tmr_load = 1'b1;
         tmr_val  = FLY_LOAD;
      end
   end

   // State, counters and decoded flags all registered together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         shots_q  <= 2'd0;
         idx_q    <= 4'd0;
         hits_q   <= 4'd0;
         round_q  <= 4'd1;
         score_q  <= '0;
         active_q <= 1'b0;
         spawn_q  <= 1'b0;
         fall_q   <= 1'b0;
         escape_q <= 1'b0;
         over_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shots_q  <= shots_d;
         idx_q    <= idx_d;
         hits_q   <= hits_d;
         round_q  <= round_d;
         score_q  <= score_d;
         active_q <= (state_d == StFlying);
         spawn_q  <= (state_d == StSpawn);
         fall_q   <= (state_d == StHit);
         escape_q <= (state_d == StEscape);
         over_q   <= (state_d == StGameOver);
      end
   end

   assign state       = state_q;
   assign duck_active = active_q;
   assign duck_spawn  = spawn_q;
   assign duck_fall   = fall_q;
   assign duck_escape = escape_q;
   assign shots_left  = shots_q;
   assign duck_idx    = idx_q;
   assign ducks_hit   = hits_q;
   assign round       = round_q;
   assign score       = score_q;
   assign game_over   = over_q;

endmodule
